// File: rtl/servo_seq_ctrl.sv
// servo_seq_ctrl: waypoint/live sequencer that slew-limits three servo axes toward their targets.
// Define SERVO_SEQ_LOOP_EN to loop playback forever instead of stopping after the last waypoint.
module servo_seq_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int NUM_WP      = 8,
  parameter int TICK_DIV    = 50000,
  parameter int STEP        = 1,
  parameter int DWELL_TICKS = 500,
  parameter int HOME_POS    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [DATA_W-1:0] live_x,
  input  logic [DATA_W-1:0] live_y,
  input  logic [DATA_W-1:0] live_z,
  input  logic [DATA_W-1:0] rom_data_x,
  input  logic [DATA_W-1:0] rom_data_y,
  input  logic [DATA_W-1:0] rom_data_z,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] pos_x,
  output logic [DATA_W-1:0] pos_y,
  output logic [DATA_W-1:0] pos_z,
  output logic              busy,
  output logic              at_target,
  output logic              done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DW = DWELL_TICKS > 1 ? $clog2(DWELL_TICKS) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, RAMP, DWELL, LIVE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [ADDR_W-1:0] wp, wp_nx;
  logic [DATA_W-1:0] tgt_x, tgt_y, tgt_z;
  logic tick, run, load_rom, load_live, slew_en, done_nx;
  // Moves p toward t by at most STEP; the step is clamped to the gap so it never overshoots or wraps.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] t);
    logic [DATA_W-1:0] d, s;
    d = p < t ? t - p : p - t;
    s = d > DATA_W'(STEP) ? DATA_W'(STEP) : d;
    return p < t ? p + s : p - s;
  endfunction
  assign tick = presc == PW'(TICK_DIV - 1);
  assign run = enable & ~stop;
  assign at_target = pos_x == tgt_x && pos_y == tgt_y && pos_z == tgt_z;
  assign busy = state != IDLE;
  assign rom_addr = wp;
  always_comb begin
    state_nx = state;
    wp_nx = wp;
    dcnt_nx = dcnt;
    load_rom = 1'b0;
    load_live = 1'b0;
    slew_en = 1'b0;
    done_nx = 1'b0;
    if (!run) begin
      state_nx = IDLE;
      dcnt_nx = '0;
    end else if (mode && state != LIVE) begin
      state_nx = LIVE;
      dcnt_nx = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nx = FETCH;
          wp_nx = '0;
        end
        FETCH: state_nx = LATCH;
        LATCH: begin
          load_rom = 1'b1;
          state_nx = RAMP;
        end
        RAMP: begin
          slew_en = tick;
          if (at_target) begin
            state_nx = DWELL;
            dcnt_nx = '0;
          end
        end
        DWELL: if (tick) begin
          dcnt_nx = dcnt + 1'b1;
          if (dcnt == DW'(DWELL_TICKS - 1)) begin
            dcnt_nx = '0;
`ifdef SERVO_SEQ_LOOP_EN
            state_nx = FETCH;
            wp_nx = wp == ADDR_W'(NUM_WP - 1) ? '0 : wp + 1'b1;
`else
            state_nx = wp == ADDR_W'(NUM_WP - 1) ? IDLE : FETCH;
            wp_nx = wp == ADDR_W'(NUM_WP - 1) ? wp : wp + 1'b1;
            done_nx = wp == ADDR_W'(NUM_WP - 1);
`endif
          end
        end
        LIVE: begin
          load_live = mode;
          slew_en = mode & tick;
          state_nx = mode ? LIVE : IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      dcnt <= '0;
      wp <= '0;
      done <= 1'b0;
      pos_x <= DATA_W'(HOME_POS);
      pos_y <= DATA_W'(HOME_POS);
      pos_z <= DATA_W'(HOME_POS);
      tgt_x <= DATA_W'(HOME_POS);
      tgt_y <= DATA_W'(HOME_POS);
      tgt_z <= DATA_W'(HOME_POS);
    end else begin
      state <= state_nx;
      presc <= tick ? '0 : presc + 1'b1;
      dcnt <= dcnt_nx;
      wp <= wp_nx;
      done <= done_nx;
      if (load_rom) begin
        tgt_x <= rom_data_x;
        tgt_y <= rom_data_y;
        tgt_z <= rom_data_z;
      end else if (load_live) begin
        tgt_x <= live_x;
        tgt_y <= live_y;
        tgt_z <= live_z;
      end
      if (slew_en) begin
        pos_x <= slew(pos_x, tgt_x);
        pos_y <= slew(pos_y, tgt_y);
        pos_z <= slew(pos_z, tgt_z);
      end
    end
  end
endmodule
